// File: rtl/aes_pkg.sv
// Shared AES types, state encoding, S-box table and GF(2^8) helper.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } aes_state_e;

  localparam int AES128_ROUNDS = 10;

  // Forward S-box, entry 0 first (row-major, 16 bytes per row).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box, pure table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: loads a cipher key, then emits round
// keys 0..10, computing each next key from the current one on handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both high; the source holds its payload
// stable while valid is high and ready is low, and valid never depends
// on ready. key_ready is high only in IDLE; rk_valid only in EMIT.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  aes_state_e state_q, state_d;
  aes_block_t rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;

  aes_word_t  w0, w1, w2, w3;
  aes_word_t  rot_w, sub_w, t_w;
  aes_word_t  n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_q;

  // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord through the single shared bank of four S-boxes
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*g +: 8]),
      .out_byte (sub_w[8*g +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon_q, 24'h0};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  // Output decode: status comes straight from the state register
  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign rk_out    = rk_q;
  assign rk_idx    = idx_q;
  assign rk_last   = (state_q == EMIT) && (idx_q == LAST_IDX);

  // Next-state logic: load on key handshake, advance on round-key handshake
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          rk_d    = key_in;
          rcon_d  = 8'h01;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            rk_d   = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: reference key schedule with an S-box
// derived arithmetically (GF inverse + affine map), expected queue of
// {idx, round_key}, and FIPS-197 constants for spot checks.
module tb_aes_key_expand_seq;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_ALT = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  logic [131:0] exp_q[$];
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  int n_cmp;
  int n_mis;

  aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_sbox();
    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
  endtask

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, sub, t;
    {w0, w1, w2, w3} = k;
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox_m[rot[31:24]], sbox_m[rot[23:16]], sbox_m[rot[15:8]], sbox_m[rot[7:0]]};
    t   = sub ^ {rc, 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Push the 11 expected {idx, round key} entries for one cipher key.
  task automatic push_stream(input logic [127:0] key);
    logic [127:0] cur = key;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back({4'(i), cur});
      if (i < 10) cur = next_rk(cur, rcon_tab[i]);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge while IDLE; returns at the negedge after acceptance.
  task automatic send_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({key_ready, rk_valid, rk_last, busy, rk_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_mis++;
      $display("FAIL reset_status: got rdy/vld/last/busy/idx=%b%b%b%b/%0d required 1000/0",
               key_ready, rk_valid, rk_last, busy, rk_idx);
    end
    n_cmp++;
    if (rk_out !== 128'h0) begin
      n_mis++; $display("FAIL reset_rk_out: got %h required 0", rk_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      n_mis++; $display("FAIL post_reset_idle: got rdy=%b vld=%b required 1/0", key_ready, rk_valid);
    end
  endtask

  task automatic test_fips_stream();
    logic [131:0] e;
    logic [127:0] spec_v;
    rk_ready = 1'b1;
    push_stream(KEY_A1);
    send_key(KEY_A1);
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (rk_valid !== 1'b1) begin
        n_mis++; $display("FAIL a1_valid beat %0d: got %b required 1", i, rk_valid);
      end
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
      n_cmp++;
      if ({rk_idx, rk_out} !== e) begin
        n_mis++; $display("FAIL a1_beat %0d: got %h/%h required %h/%h", i, rk_idx, rk_out, e[131:128], e[127:0]);
      end
      n_cmp++;
      if (rk_last !== (i == 10)) begin
        n_mis++; $display("FAIL a1_last beat %0d: got %b required %b", i, rk_last, (i == 10));
      end
      if (i == 0 || i == 1 || i == 2 || i == 10) begin
        spec_v = (i == 0) ? KEY_A1 : (i == 1) ? A1_R1 : (i == 2) ? A1_R2 : A1_R10;
        n_cmp++;
        if (rk_out !== spec_v) begin
          n_mis++; $display("FAIL a1_fips round %0d: got %h required %h", i, rk_out, spec_v);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++; $display("FAIL a1_end_idle: got vld=%b rdy=%b busy=%b required 0/1/0", rk_valid, key_ready, busy);
    end
  endtask

  task automatic test_zero_key();
    logic [131:0] e;
    rk_ready = 1'b1;
    push_stream(128'h0);
    send_key(128'h0);
    for (int i = 0; i < 11; i++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
      n_cmp++;
      if (rk_valid !== 1'b1 || {rk_idx, rk_out} !== e) begin
        n_mis++; $display("FAIL zero_beat %0d: got v=%b %h/%h required %h/%h", i, rk_valid, rk_idx, rk_out, e[131:128], e[127:0]);
      end
      if (i == 1 || i == 10) begin
        n_cmp++;
        if (rk_out !== ((i == 1) ? Z_R1 : Z_R10)) begin
          n_mis++; $display("FAIL zero_fips round %0d: got %h required %h", i, rk_out, (i == 1) ? Z_R1 : Z_R10);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [131:0] e;
    logic [127:0] snap_out;
    logic [3:0]   snap_idx;
    logic         snap_last;
    logic         stall = 1'b0;
    logic         r;
    int           acc = 0;
    rk_ready = 1'b0;
    push_stream(KEY_A1);
    send_key(KEY_A1);
    for (int c = 0; c < 300 && acc < 11; c++) begin
      if (stall) begin
        n_cmp++;
        if (rk_valid !== 1'b1 || rk_out !== snap_out || rk_idx !== snap_idx || rk_last !== snap_last) begin
          n_mis++; $display("FAIL bp_hold cycle %0d: got v=%b %h/%h required 1 %h/%h", c, rk_valid, rk_idx, rk_out, snap_idx, snap_out);
        end
      end
      r = (c >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rk_valid && r) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
        n_cmp++;
        if ({rk_idx, rk_out} !== e || rk_last !== (acc == 10)) begin
          n_mis++; $display("FAIL bp_beat %0d: got %h/%h last=%b required %h/%h", acc, rk_idx, rk_out, rk_last, e[131:128], e[127:0]);
        end
        acc++;
      end
      stall     = rk_valid && !r;
      snap_out  = rk_out;
      snap_idx  = rk_idx;
      snap_last = rk_last;
      rk_ready  = r;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    n_cmp++;
    if (acc != 11) begin
      n_mis++; $display("FAIL bp_timeout: got %0d beats required 11", acc);
    end
    n_cmp++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_mis++; $display("FAIL bp_end_idle: got vld=%b rdy=%b required 0/1", rk_valid, key_ready);
    end
  endtask

  task automatic test_key_ignored();
    logic [131:0] e;
    rk_ready = 1'b1;
    push_stream(KEY_A1);
    send_key(KEY_A1);
    for (int i = 0; i < 11; i++) begin
      if (i == 1) begin key_in = KEY_ALT; key_valid = 1'b1; end
      if (i == 8) key_valid = 1'b0;
      n_cmp++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
        n_mis++; $display("FAIL busy_ready beat %0d: got rdy=%b busy=%b required 0/1", i, key_ready, busy);
      end
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
      n_cmp++;
      if (rk_valid !== 1'b1 || {rk_idx, rk_out} !== e) begin
        n_mis++; $display("FAIL busy_beat %0d: got v=%b %h/%h required %h/%h", i, rk_valid, rk_idx, rk_out, e[131:128], e[127:0]);
      end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_mis++; $display("FAIL busy_no_stale_load: got vld=%b rdy=%b required 0/1", rk_valid, key_ready);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [131:0] e;
    rk_ready = 1'b1;
    push_stream(KEY_A1);
    send_key(KEY_A1);
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
      n_cmp++;
      if ({rk_idx, rk_out} !== e) begin
        n_mis++; $display("FAIL rst_pre beat %0d: got %h/%h required %h/%h", i, rk_idx, rk_out, e[131:128], e[127:0]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rk_idx !== 4'd5 || rk_valid !== 1'b1) begin
      n_mis++; $display("FAIL rst_at_idx5: got idx=%0d v=%b required 5/1", rk_idx, rk_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rk_valid !== 1'b0 || rk_out !== 128'h0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      n_mis++; $display("FAIL rst_async: got v=%b out=%h busy=%b rdy=%b required 0/0/0/1", rk_valid, rk_out, busy, key_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_fips_stream();
  endtask

  task automatic test_back_to_back();
    logic [131:0] e;
    rk_ready  = 1'b1;
    push_stream(KEY_A1);
    key_in    = KEY_A1;
    key_valid = 1'b1;
    @(negedge clk);
    key_in = 128'h0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 11; i++) begin
        if (s == 1 && i == 0) key_valid = 1'b0;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
        n_cmp++;
        if (rk_valid !== 1'b1 || {rk_idx, rk_out} !== e) begin
          n_mis++; $display("FAIL b2b stream %0d beat %0d: got v=%b %h/%h required %h/%h", s, i, rk_valid, rk_idx, rk_out, e[131:128], e[127:0]);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
        n_mis++; $display("FAIL b2b_gap stream %0d: got vld=%b rdy=%b required 0/1", s, rk_valid, key_ready);
      end
      if (s == 0) begin
        push_stream(128'h0);
        @(negedge clk);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_mis = 0;
    build_sbox();
    test_reset();
    test_fips_stream();
    test_zero_key();
    test_backpressure();
    test_key_ignored();
    test_reset_mid_stream();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
